screen_arbiter: RTL and testbench

Shares one `screen_writer` pixel-sweep engine between up to `N_REQ` drawing clients, such as several `draw_triangle` instances and a screen-clear unit. Each client presents a rectangle request and a per-pixel colour. The arbiter grants one client at a time, latches that client's rectangle into the writer and pulses `screen_start`. It routes writer feedback (`screen_x`, `screen_y`, `old_screen_colour`) back to the owner and returns a per-client done pulse. It sits between the drawing clients and `screen_writer`, replacing the direct point-to-point hookup.

---
 rtl/screen_arbiter.sv | 149 ++++++++++++++
 tb/tb_screen_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_arbiter.sv
// screen_arbiter: shares one screen_writer sweep engine between N_REQ drawing clients.
// Define SCREEN_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module screen_arbiter #(
   parameter int WIDTH        = 8,
   parameter int COLOUR_WIDTH = 3,
   parameter int N_REQ        = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req_start,
   input  logic [N_REQ*COLOUR_WIDTH-1:0] req_colour,
   input  logic [N_REQ*WIDTH-1:0]        req_x_min,
   input  logic [N_REQ*WIDTH-1:0]        req_y_min,
   input  logic [N_REQ*WIDTH-1:0]        req_x_range,
   input  logic [N_REQ*WIDTH-1:0]        req_y_range,
   output logic [N_REQ-1:0]              req_grant,
   output logic [N_REQ-1:0]              req_done,
   output logic [WIDTH-1:0]              req_x,
   output logic [WIDTH-1:0]              req_y,
   output logic [COLOUR_WIDTH-1:0]       req_old_colour,
   output logic                          screen_start,
   output logic [COLOUR_WIDTH-1:0]       new_screen_colour,
   output logic [WIDTH-1:0]              screen_x_min,
   output logic [WIDTH-1:0]              screen_y_min,
   output logic [WIDTH-1:0]              screen_x_range,
   output logic [WIDTH-1:0]              screen_y_range,
   input  logic [WIDTH-1:0]              screen_x,
   input  logic [WIDTH-1:0]              screen_y,
   input  logic [COLOUR_WIDTH-1:0]       old_screen_colour,
   input  logic                          screen_done
);
   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_BUSY  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [WIDTH-1:0] x_min_q, x_min_d, y_min_q, y_min_d;
   logic [WIDTH-1:0] x_rng_q, x_rng_d, y_rng_q, y_rng_d;
   logic [OW-1:0]    win;
   logic             found;
   int               idx;

`ifdef SCREEN_ARB_ROUND_ROBIN_EN
   logic [OW-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == S_DONE) begin
         ptr_d = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
`endif

   // First requester found scanning upward from the start index, wrapping at N_REQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
`ifdef SCREEN_ARB_ROUND_ROBIN_EN
         idx = (int'(ptr_q) + k) % N_REQ;
`else
         idx = k;
`endif
         if (!found && req_start[OW'(idx)]) begin
            found = 1'b1;
            win   = OW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      grant_d = grant_q;
      x_min_d = x_min_q;
      y_min_d = y_min_q;
      x_rng_d = x_rng_q;
      y_rng_d = y_rng_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d      = S_START;
               owner_d      = win;
               grant_d      = '0;
               grant_d[win] = 1'b1;
               x_min_d      = req_x_min[int'(win)*WIDTH +: WIDTH];
               y_min_d      = req_y_min[int'(win)*WIDTH +: WIDTH];
               x_rng_d      = req_x_range[int'(win)*WIDTH +: WIDTH];
               y_rng_d      = req_y_range[int'(win)*WIDTH +: WIDTH];
            end
         end
         S_START: state_d = S_BUSY;
         S_BUSY: begin
            if (screen_done) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         grant_q <= '0;
         x_min_q <= '0;
         y_min_q <= '0;
         x_rng_q <= '0;
         y_rng_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         x_min_q <= x_min_d;
         y_min_q <= y_min_d;
         x_rng_q <= x_rng_d;
         y_rng_q <= y_rng_d;
      end
   end

   assign req_grant      = grant_q;
   assign req_done       = (state_q == S_DONE) ? grant_q : '0;
   assign screen_start   = (state_q == S_START);
   assign screen_x_min   = x_min_q;
   assign screen_y_min   = y_min_q;
   assign screen_x_range = x_rng_q;
   assign screen_y_range = y_rng_q;
   assign req_x          = screen_x;
   assign req_y          = screen_y;
   assign req_old_colour = old_screen_colour;

   // Colour stays combinational: clients derive it from the pixel the writer is on right now.
   assign new_screen_colour = (grant_q != '0) ?
                              req_colour[int'(owner_q)*COLOUR_WIDTH +: COLOUR_WIDTH] : '0;
endmodule

// File: tb/tb_screen_arbiter.sv
// Bench for screen_arbiter: timeline reference model plus bench-side writer and clients.
// Follows SCREEN_ARB_ROUND_ROBIN_EN to choose the expected arbitration policy.
`timescale 1ns/1ps
module tb_screen_arbiter;
   localparam int W  = 8;
   localparam int CW = 3;
   localparam int N  = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_start = '0;
   logic [N*CW-1:0] req_colour = '0;
   logic [N*W-1:0]  req_x_min = '0, req_y_min = '0, req_x_range = '0, req_y_range = '0;
   logic [N-1:0]    req_grant, req_done;
   logic [W-1:0]    req_x, req_y;
   logic [CW-1:0]   req_old_colour;
   logic            screen_start;
   logic [CW-1:0]   new_screen_colour;
   logic [W-1:0]    screen_x_min, screen_y_min, screen_x_range, screen_y_range;
   logic [W-1:0]    screen_x = '0, screen_y = '0;
   logic [CW-1:0]   old_screen_colour = '0;
   logic            screen_done = 1'b0;

   screen_arbiter #(.WIDTH(W), .COLOUR_WIDTH(CW), .N_REQ(N)) dut (
      .clock(clock), .reset(reset), .req_start(req_start), .req_colour(req_colour),
      .req_x_min(req_x_min), .req_y_min(req_y_min), .req_x_range(req_x_range),
      .req_y_range(req_y_range), .req_grant(req_grant), .req_done(req_done),
      .req_x(req_x), .req_y(req_y), .req_old_colour(req_old_colour),
      .screen_start(screen_start), .new_screen_colour(new_screen_colour),
      .screen_x_min(screen_x_min), .screen_y_min(screen_y_min),
      .screen_x_range(screen_x_range), .screen_y_range(screen_y_range),
      .screen_x(screen_x), .screen_y(screen_y), .old_screen_colour(old_screen_colour),
      .screen_done(screen_done)
   );

   always #5 clock = ~clock;

   int n_tests = 0, n_fail = 0, cyc = 0;
   // clients
   logic [N-1:0]  rq = '0;
   int            gx[N], gy[N], gxr[N], gyr[N], pend[N], cmode[N];
   logic [CW-1:0] fcol[N], rcol[N];
   bit            grant_seen[N];
   int            done_log[$];
   // writer
   bit  w_arm = 0, w_active = 0, inj_done = 0;
   int  w_idx, w_total, w_xmin, w_ymin, w_xr, last_sd = -10;
   int  pix_cnt, pix_101, pix_par, pix_xsum;
   // reference model: owner, cycle of grant, cycle screen_done was accepted
   int            m_owner = -1, m_gat = 0, m_dseen = -1, m_ptr = 0;
   logic [W-1:0]  m_xmin = '0, m_ymin = '0, m_xr = '0, m_yr = '0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [CW-1:0] colour_of(int i);
      case (cmode[i])
         0:       return fcol[i];
         1:       return screen_x[0] ? 3'b111 : 3'b000;
         default: return rcol[i];
      endcase
   endfunction

   function automatic int pick();
      int i;
      for (int k = 0; k < N; k++) begin
`ifdef SCREEN_ARB_ROUND_ROBIN_EN
         i = (m_ptr + k) % N;
`else
         i = k;
`endif
         if (rq[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step();
      int w;
      if (reset) begin
         m_owner = -1; m_dseen = -1; m_ptr = 0;
         m_xmin = '0; m_ymin = '0; m_xr = '0; m_yr = '0;
      end else if (m_owner < 0) begin
         w = pick();
         if (w >= 0) begin
            m_owner = w; m_gat = cyc; m_dseen = -1;
            m_xmin = W'(gx[w]); m_ymin = W'(gy[w]); m_xr = W'(gxr[w]); m_yr = W'(gyr[w]);
         end
      end else if (m_dseen >= 0) begin
         if (cyc == m_dseen + 2) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
      end else if (cyc - 1 > m_gat && screen_done) begin
         m_dseen = cyc - 1;
      end
   endtask

   task automatic set_xy();
      screen_x = W'(w_xmin + (w_idx % (w_xr + 1)));
      screen_y = W'(w_ymin + (w_idx / (w_xr + 1)));
   endtask

   task automatic writer_step();
      if (reset) begin
         w_arm = 0; w_active = 0; screen_done = 1'b0; inj_done = 0;
      end else begin
         screen_done = inj_done;
         inj_done    = 0;
         if (w_active) begin
            w_idx++;
            if (w_idx == w_total) begin
               screen_done = 1'b1; w_active = 0; last_sd = cyc;
            end else set_xy();
         end
         if (w_arm) begin
            w_arm = 0; w_active = 1; w_idx = 0; set_xy();
         end
      end
      old_screen_colour = CW'($urandom);
   endtask

   task automatic compare();
      logic [N-1:0] eg, ed;
      eg = '0; ed = '0;
      if (m_owner >= 0) begin
         eg = N'(1) << m_owner;
         if (m_dseen >= 0 && cyc == m_dseen + 1) ed = eg;
      end
      chk("grant", 32'(req_grant), 32'(eg));
      chk("done", 32'(req_done), 32'(ed));
      chk("start", 32'(screen_start), 32'(m_owner >= 0 && cyc == m_gat));
      chk("x_min", 32'(screen_x_min), 32'(m_xmin));
      chk("y_min", 32'(screen_y_min), 32'(m_ymin));
      chk("x_range", 32'(screen_x_range), 32'(m_xr));
      chk("y_range", 32'(screen_y_range), 32'(m_yr));
      chk("colour", 32'(new_screen_colour), 32'((m_owner >= 0) ? colour_of(m_owner) : 3'b000));
      chk("req_x", 32'(req_x), 32'(screen_x));
      chk("req_y", 32'(req_y), 32'(screen_y));
      chk("req_old", 32'(req_old_colour), 32'(old_screen_colour));
   endtask

   task automatic observe();
      if (w_active) begin
         pix_cnt++;
         if (new_screen_colour == 3'b101) pix_101++;
         if (new_screen_colour == (screen_x[0] ? 3'b111 : 3'b000)) pix_par++;
         pix_xsum += int'(screen_x);
      end
      for (int i = 0; i < N; i++) begin
         if (req_grant[i]) grant_seen[i] = 1;
         if (req_done[i]) begin
            done_log.push_back(i);
            if (pend[i] > 0) pend[i]--;
            rq[i] = (pend[i] > 0);
         end
      end
      if (screen_start) begin
         w_arm = 1; w_xmin = int'(screen_x_min); w_ymin = int'(screen_y_min);
         w_xr = int'(screen_x_range); w_total = (w_xr + 1) * (int'(screen_y_range) + 1);
      end
   endtask

   task automatic tick();
      req_start = rq;
      for (int i = 0; i < N; i++) begin
         req_x_min[i*W +: W]   = W'(gx[i]);
         req_y_min[i*W +: W]   = W'(gy[i]);
         req_x_range[i*W +: W] = W'(gxr[i]);
         req_y_range[i*W +: W] = W'(gyr[i]);
      end
      @(posedge clock);
      #1;
      cyc++;
      model_step();
      writer_step();
      for (int i = 0; i < N; i++) begin
         rcol[i] = CW'($urandom);
         req_colour[i*CW +: CW] = colour_of(i);
      end
      #1;
      compare();
      observe();
   endtask

   task automatic request(int i, int n, int x, int y, int xr, int yr);
      gx[i] = x; gy[i] = y; gxr[i] = xr; gyr[i] = yr; pend[i] = n; rq[i] = 1'b1;
   endtask

   task automatic wait_quiet(int budget);
      int n;
      n = 0;
      while ((rq != '0 || req_grant != '0 || w_active || w_arm) && n < budget) begin
         tick(); n++;
      end
      chk("quiet_timeout", 32'(n < budget), 32'd1);
   endtask

   task automatic wait_start(int budget);
      int n;
      n = 0;
      while (!screen_start && n < budget) begin tick(); n++; end
      chk("start_timeout", 32'(n < budget), 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(); tick(); reset = 1'b0;
   endtask

   initial begin : main
      int n, base;
      int exp_order[5];
      for (int i = 0; i < N; i++) begin
         gx[i] = 0; gy[i] = 0; gxr[i] = 0; gyr[i] = 0; pend[i] = 0; cmode[i] = 2;
         fcol[i] = '0; rcol[i] = '0; grant_seen[i] = 0;
      end
      do_reset();
      chk("rst_grant", 32'(req_grant), 32'd0);
      chk("rst_start", 32'(screen_start), 32'd0);
      chk("rst_colour", 32'(new_screen_colour), 32'd0);
      chk("rst_xmin", 32'(screen_x_min), 32'd0);

      // single request from client 2
      cmode[2] = 0; fcol[2] = 3'b101;
      pix_cnt = 0; pix_101 = 0; pix_xsum = 0;
      request(2, 1, 10, 20, 3, 1);
      tick();
      chk("t1_grant", 32'(req_grant), 32'h4);
      chk("t1_start", 32'(screen_start), 32'd1);
      chk("t1_xmin", 32'(screen_x_min), 32'd10);
      n = 0;
      while (req_done == '0 && n < 100) begin tick(); n++; end
      chk("t1_done_seen", 32'(n < 100), 32'd1);
      chk("t1_done", 32'(req_done), 32'h4);
      chk("t1_done_lat", 32'(cyc), 32'(last_sd + 1));
      tick();
      chk("t1_done_once", 32'(req_done), 32'd0);
      chk("t1_pixels", 32'(pix_cnt), 32'd8);
      chk("t1_pix_col", 32'(pix_101), 32'd8);
      chk("t1_xsum", 32'(pix_xsum), 32'd92);
      wait_quiet(50);

      // contention from a fresh pointer; client 0 keeps requesting for a second rectangle
      do_reset();
      done_log.delete();
      request(0, 2, 1, 1, 1, 0);
      request(1, 1, 2, 2, 0, 1);
      request(2, 1, 3, 3, 2, 0);
      request(3, 1, 4, 4, 1, 1);
      wait_quiet(500);
`ifdef SCREEN_ARB_ROUND_ROBIN_EN
      exp_order = '{0, 1, 2, 3, 0};
`else
      exp_order = '{0, 0, 1, 2, 3};
`endif
      chk("t2_count", 32'(done_log.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (k < done_log.size()) chk("t2_order", 32'(done_log[k]), 32'(exp_order[k]));
      end

      // per-pixel colour follows screen_x parity with zero lag
      cmode[1] = 1; pix_cnt = 0; pix_par = 0;
      request(1, 1, 5, 0, 7, 1);
      wait_quiet(200);
      chk("t3_pixels", 32'(pix_cnt), 32'd16);
      chk("t3_parity", 32'(pix_par), 32'd16);

      // geometry held while the owner's inputs change; stray done in idle ignored
      request(0, 1, 10, 0, 7, 3);
      wait_start(20);
      for (int k = 0; k < 6; k++) tick();
      gx[0] = 50;
      for (int k = 0; k < 4; k++) tick();
      chk("t4_xmin_held", 32'(screen_x_min), 32'd10);
      wait_quiet(200);
      base = done_log.size();
      inj_done = 1;
      for (int k = 0; k < 4; k++) tick();
      chk("t4_stray", 32'(done_log.size()), 32'(base));

      // reset in the middle of client 1's sweep with client 3 pending
      request(1, 1, 0, 0, 7, 7);
      wait_start(20);
      for (int k = 0; k < 3; k++) tick();
      request(3, 1, 9, 9, 1, 0);
      tick();
      base = done_log.size();
      reset = 1'b1; rq[1] = 1'b0; pend[1] = 0;
      tick();
      chk("t5_grant0", 32'(req_grant), 32'd0);
      chk("t5_done0", 32'(req_done), 32'd0);
      chk("t5_start0", 32'(screen_start), 32'd0);
      chk("t5_geom0", 32'({screen_x_min, screen_y_min, screen_x_range, screen_y_range}), 32'd0);
      chk("t5_colour0", 32'(new_screen_colour), 32'd0);
      reset = 1'b0;
      tick();
      chk("t5_grant3", 32'(req_grant), 32'h8);
      wait_quiet(100);
      chk("t5_dones", 32'(done_log.size()), 32'(base + 1));
      if (done_log.size() == base + 1) chk("t5_who", 32'(done_log[base]), 32'd3);

      // withdrawal of client 1 while client 0 is busy
      done_log.delete();
      for (int i = 0; i < N; i++) grant_seen[i] = 0;
      request(0, 1, 0, 0, 3, 3);
      wait_start(20);
      for (int k = 0; k < 4; k++) tick();
      gx[1] = 7; rq[1] = 1'b1;
      tick();
      rq[1] = 1'b0;
      wait_quiet(100);
      for (int k = 0; k < 3; k++) tick();
      chk("t6_no_grant1", 32'(grant_seen[1]), 32'd0);
      chk("t6_dones", 32'(done_log.size()), 32'd1);
      if (done_log.size() == 1) chk("t6_who", 32'(done_log[0]), 32'd0);

      // randomized traffic, checked every cycle against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!rq[i] && pend[i] == 0 && $urandom_range(0, 15) == 0) begin
               cmode[i] = int'($urandom_range(0, 2));
               fcol[i]  = CW'($urandom);
               request(i, 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end else if (rq[i] && !req_grant[i] && $urandom_range(0, 39) == 0) begin
               rq[i] = 1'b0; pend[i] = 0;
            end
         end
         if (req_grant == '0 && $urandom_range(0, 29) == 0) inj_done = 1;
         reset = ($urandom_range(0, 599) == 0);
         tick();
      end
      reset = 1'b0;
      wait_quiet(2000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
